seq_detector_param: RTL and testbench

- Parametrised Moore serial-pattern detector; next generation of the fixed 4-bit, non-overlapping detector.
- Pattern and pattern length are runtime-programmable up to MAX_LEN bits.
- Overlapping and non-overlapping modes are selected by a port.
- Serial input is qualified by a valid strobe.
- Sits on serial data links, e.g. sync-word and frame-marker detection; output feeds framing/control logic.

---
 rtl/seq_detector_pkg.sv | 45 ++++
 rtl/seq_match_cmp.sv | 32 +++
 rtl/seq_detector_param.sv | 127 ++++++++++++
 tb/tb_seq_detector_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_pkg
//  Description : Shared constants, types and helpers for the parametrised
//                serial-pattern detector. The configuration bundle is sized
//                for the largest supported pattern (32 bits). Narrower
//                instances zero-extend into it, and the unused upper bits are
//                constant and are pruned by synthesis.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_detector_pkg;

    // Default and upper bound for the pattern length.
    localparam int unsigned C_MAX_LEN_DEFAULT = 8;
    localparam int unsigned C_PAT_W           = 32;

    // Width needed to hold a length value 0..max_len.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam int unsigned C_LEN_W_LIMIT = len_width(C_PAT_W);

    // Configuration bundle held in the shadow registers.
    typedef struct packed {
        logic [C_PAT_W-1:0]       pattern;
        logic [C_LEN_W_LIMIT-1:0] len;
        logic                     overlap;
    } cfg_t;

    // Reset values of the shadow configuration.
    localparam logic [C_PAT_W-1:0] C_RST_PATTERN = '0;
    localparam logic               C_RST_OVERLAP = 1'b0;

    // The reset length equals the instance's MAX_LEN, so it is built by a function.
    function automatic cfg_t rst_cfg(input int unsigned max_len);
        cfg_t c;
        c.pattern = C_RST_PATTERN;
        c.len     = C_LEN_W_LIMIT'(max_len);
        c.overlap = C_RST_OVERLAP;
        return c;
    endfunction

endpackage : seq_detector_pkg
`default_nettype wire

// File: rtl/seq_match_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : seq_match_cmp
//  Description : Combinational masked compare. It asserts o_match when the
//                low i_len bits of i_hist equal the low i_len bits of
//                i_pattern. Bits at or above i_len are ignored.
//  Ports       : i_hist    - shift history, newest bit at bit 0
//                i_pattern - programmed pattern, last expected bit at bit 0
//                i_len     - active length in bits
//                o_match   - masked equality result
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_match_cmp
    import seq_detector_pkg::*;
(
    input  logic [C_PAT_W-1:0]       i_hist,
    input  logic [C_PAT_W-1:0]       i_pattern,
    input  logic [C_LEN_W_LIMIT-1:0] i_len,
    output logic                     o_match
);

    logic [C_PAT_W-1:0] w_mask;

    // Thermometer mask: bit i is active when i < len.
    for (genvar i = 0; i < C_PAT_W; i++) begin : g_mask
        assign w_mask[i] = (C_LEN_W_LIMIT'(i) < i_len);
    end

    assign o_match = (((i_hist ^ i_pattern) & w_mask) == '0);

endmodule : seq_match_cmp
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Moore serial-pattern detector with a programmable pattern
//                and length (1..MAX_LEN). Overlapping or non-overlapping
//                detection is selectable. Serial bits are qualified by
//                x_valid. z is registered and pulses for one cycle after the
//                edge that accepts a completing bit.
//  Option      : define SEQ_DETECTOR_MATCH_CNT_EN to add the saturating
//                match_cnt output and its counter.
//  Ports       : clk         - rising-edge clock
//                reset       - asynchronous reset, active low
//                x, x_valid  - serial bit and its qualifier
//                cfg_pattern - pattern, bit [cfg_len-1] arrives first
//                cfg_len     - active length; 0 or >MAX_LEN maps to MAX_LEN
//                cfg_overlap - 1 = overlapping detection
//                cfg_load    - latch cfg_* and clear detection history
//                z           - match pulse
//                match_cnt   - saturating match count (option only)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int unsigned MAX_LEN = C_MAX_LEN_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          x,
    input  logic                          x_valid,
    input  logic [MAX_LEN-1:0]            cfg_pattern,
    input  logic [len_width(MAX_LEN)-1:0] cfg_len,
    input  logic                          cfg_overlap,
    input  logic                          cfg_load,
    output logic                          z
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]              match_cnt
`endif
);

    localparam int unsigned        LEN_W       = len_width(MAX_LEN);
    localparam logic [LEN_W-1:0]   C_MAX_LEN_L = LEN_W'(MAX_LEN);

    if (MAX_LEN < 2 || MAX_LEN > C_PAT_W || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: MAX_LEN must be 2..32 and CNT_W >= 1");
    end

    cfg_t               r_shadow;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_z;

    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [LEN_W-1:0]   w_load_len;
    cfg_t               w_load_cfg;
    logic               w_cmp_match;
    logic               w_hit;

    // Length clamp applied at load time, so detection never sees an illegal length.
    assign w_load_len         = (cfg_len == '0 || cfg_len > C_MAX_LEN_L) ? C_MAX_LEN_L : cfg_len;
    assign w_load_cfg.pattern = C_PAT_W'(cfg_pattern);
    assign w_load_cfg.len     = C_LEN_W_LIMIT'(w_load_len);
    assign w_load_cfg.overlap = cfg_overlap;

    // Values after accepting x. The match is judged on these, not on the current registers.
    assign w_hist_next = {r_hist[MAX_LEN-2:0], x};
    assign w_fill_next = (r_fill == C_MAX_LEN_L) ? r_fill : r_fill + 1'b1;

    seq_match_cmp u_cmp (
        .i_hist    (C_PAT_W'(w_hist_next)),
        .i_pattern (r_shadow.pattern),
        .i_len     (r_shadow.len),
        .o_match   (w_cmp_match)
    );

    // A match also needs at least len fresh bits since the last clear.
    assign w_hit = x_valid && !cfg_load && w_cmp_match
                   && (C_LEN_W_LIMIT'(w_fill_next) >= r_shadow.len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= rst_cfg(MAX_LEN);
            r_hist   <= '0;
            r_fill   <= '0;
            r_z      <= 1'b0;
        end else if (cfg_load) begin
            r_shadow <= w_load_cfg;
            r_hist   <= '0;
            r_fill   <= '0;
            r_z      <= 1'b0;
        end else if (x_valid) begin
            r_hist <= w_hist_next;
            r_z    <= w_hit;
            // Non-overlap restarts the fill count so the next match needs len new bits.
            if (w_hit && !r_shadow.overlap) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_next;
            end
        end else begin
            r_z <= 1'b0;
        end
    end

    assign z = r_z;

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    logic [CNT_W-1:0] r_match_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_match_cnt <= '0;
        end else if (cfg_load) begin
            r_match_cnt <= '0;
        end else if (w_hit && (r_match_cnt != '1)) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign match_cnt = r_match_cnt;
`endif

endmodule : seq_detector_param
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Scoreboard bench for seq_detector_param. A bit-list
//                reference model produces the expected z and count for every
//                clock, and a negedge monitor compares them with the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               x = 1'b0;
    logic               x_valid = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cfg_load = 1'b0;
    logic               z;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_load    (cfg_load),
        .z           (z)
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt)
`endif
    );

    typedef struct {
        logic z;
        int   cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: the list of fresh bits since the last clear.
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    logic               m_ovl;
    logic               m_bits[$];
    int                 m_cnt;

    task automatic model_reset();
        m_pat = '0;
        m_len = MAX_LEN;
        m_ovl = 1'b0;
        m_bits.delete();
        m_cnt = 0;
    endtask

    // The last m_len received bits, oldest first, must equal pattern[len-1] .. pattern[0].
    function automatic logic model_match();
        int n = m_bits.size();
        if (n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (m_bits[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive one clock of stimulus, then advance the model and queue its expectation.
    task automatic step(input logic xi, input logic vi, input logic li);
        exp_t e;
        x        = xi;
        x_valid  = vi;
        cfg_load = li;
        @(posedge clk);
        #1;
        e.z = 1'b0;
        if (!reset) begin
            model_reset();
        end else if (li) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 0 || int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl = cfg_overlap;
            m_bits.delete();
            m_cnt = 0;
        end else if (vi) begin
            m_bits.push_back(xi);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            e.z = model_match();
            if (e.z) begin
                if (!m_ovl) m_bits.delete();
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
        end
        e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        step(1'b0, 1'b0, 1'b1);
        // Shadow registers must ignore later changes on cfg_*.
        cfg_pattern = MAX_LEN'($urandom);
        cfg_len     = LW'($urandom);
        cfg_overlap = 1'($urandom);
    endtask

    task automatic stream(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
    endtask

    task automatic check_now(input string name);
        n_cmp++;
        if (z !== 1'b0) begin
            n_bad++;
            $display("FAIL %s z: got %b, expected 0 at %0t", name, z, $time);
        end
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
        n_cmp++;
        if (match_cnt !== '0) begin
            n_bad++;
            $display("FAIL %s cnt: got %0d, expected 0 at %0t", name, match_cnt, $time);
        end
`endif
    endtask

    // Reset is asserted between edges, and the outputs must clear before any clock edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_now(name);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
    endtask

    function automatic logic [LW-1:0] pick_len();
        int r = $urandom_range(0, 9);
        if (r < 6) return LW'($urandom_range(1, 3));
        if (r < 8) return LW'($urandom_range(4, 8));
        if (r == 8) return '0;
        return LW'($urandom_range(9, 15));
    endfunction

    // Monitor: one expectation is consumed per clock, half a period after the edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (z !== e.z) begin
                n_bad++;
                $display("FAIL z: got %b, expected %b at %0t", z, e.z, $time);
            end
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
            n_cmp++;
            if (match_cnt !== CNT_W'(e.cnt)) begin
                n_bad++;
                $display("FAIL match_cnt: got %0d, expected %0d at %0t", match_cnt, e.cnt, $time);
            end
`endif
        end
    end

    initial begin
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        reset = 1'b1;

        // Non-overlap and overlap on 1,0,1,0,1,0.
        load(8'b1010, 4, 1'b0);
        stream(32'b101010, 6);
        step(1'b0, 1'b0, 1'b0);
        load(8'b1010, 4, 1'b1);
        stream(32'b101010, 6);
        step(1'b0, 1'b0, 1'b0);

        // Gaps between bits, then a gap right after the match.
        load(8'b1010, 4, 1'b1);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);

        // Reset while z is high, and reset in the middle of a partial match.
        load(8'b1010, 4, 1'b1);
        stream(32'b1010, 4);
        async_reset("reset_with_z_high");
        step(1'b0, 1'b0, 1'b0);
        load(8'b1010, 4, 1'b1);
        stream(32'b101, 3);
        async_reset("reset_mid_stream");
        stream(32'b0, 1);
        load(8'b1010, 4, 1'b1);
        stream(32'b1010, 4);
        step(1'b0, 1'b0, 1'b0);

        // Full-length pattern, non-overlap, twice.
        load(8'hA5, 8, 1'b0);
        stream(32'hA5A5, 16);
        step(1'b0, 1'b0, 1'b0);

        // A load on the completing bit wins, and the history is cleared.
        load(8'b1010, 4, 1'b0);
        stream(32'b101, 3);
        cfg_pattern = 8'b1010; cfg_len = 4; cfg_overlap = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        stream(32'b0, 1);
        stream(32'b1010, 4);

        // len=1 in both modes, including counter saturation.
        load(8'b1, 1, 1'b1);
        stream(32'b111011, 6);
        load(8'b0, 1, 1'b0);
        stream(32'b0100, 4);

        // Length clamp: 0 and 12 both mean MAX_LEN.
        load(8'hFF, 0, 1'b1);
        stream(32'hFF, 8);
        step(1'b1, 1'b1, 1'b0);
        load(8'hF0, 12, 1'b0);
        stream(32'h1F0, 9);

        // Randomised traffic with occasional reloads, some landing on valid bits.
        for (int i = 0; i < 2500; i++) begin
            cfg_pattern = MAX_LEN'($urandom);
            cfg_len     = pick_len();
            cfg_overlap = 1'($urandom);
            step(1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0));
        end
        step(1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seq_detector_param
`default_nettype wire
